// File: rtl/up_counter_pkg.sv
// Shared types and defaults for the loadable up counter and its prescaler.
package up_counter_pkg;

    typedef enum logic {
        COUNT = 1'b0,
        HALT  = 1'b1
    } up_cnt_state_t;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_PRESCALE = 4;

    // A ratio of 1 or 2 still needs one phase bit so the vector is never zero-width.
    function automatic int prescale_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/loadable_up_counter_if.sv
// Control/status bundle of the loadable up counter; master drives commands, slave is the counter.
interface loadable_up_counter_if
    import up_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic             limit_we;
    logic [WIDTH-1:0] limit_in;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             halted;

    modport master (
        output load, enable, data_in, limit_we, limit_in, auto_reload,
        input  count, tc, wrap, halted
    );

    modport slave (
        input  load, enable, data_in, limit_we, limit_in, auto_reload,
        output count, tc, wrap, halted
    );

endinterface

// File: rtl/up_counter_prescaler.sv
// Mod-PRESCALE enable divider: tick fires on every PRESCALE-th enabled cycle.
module up_counter_prescaler
    import up_counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Enable low pauses the phase rather than clearing it.
    always_comb begin
        phase_d = phase_q;
        tick    = 1'b0;
        if (clear) begin
            phase_d = '0;
        end else if (enable) begin
            if (phase_q == LAST) begin
                phase_d = '0;
                tick    = 1'b1;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/loadable_up_counter.sv
// Loadable up counter with programmable limit; wraps to 0 (auto-reload) or halts at the limit.
// Define UP_COUNTER_PRESCALE_EN to advance only on every PRESCALE-th enabled cycle.
module loadable_up_counter
    import up_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input logic                  clk,
    input logic                  rst_n,
    loadable_up_counter_if.slave bus
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("loadable_up_counter: PRESCALE must be >= 1");
    end

    up_cnt_state_t    state_q;
    up_cnt_state_t    state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             halted_q;
    logic             halted_d;

    logic advance_req;
    logic step;

    assign advance_req = bus.enable && !bus.load && (state_q == COUNT);

`ifdef UP_COUNTER_PRESCALE_EN
    logic presc_tick;

    up_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.load),
        .enable (advance_req),
        .tick   (presc_tick)
    );

    assign step = advance_req && presc_tick;
`else
    assign step = advance_req;
`endif

    // All decisions compare against the pre-edge limit; a newly written limit takes effect next cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = bus.limit_we ? bus.limit_in : limit_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = bus.data_in;
            state_d = COUNT;
        end else if (step) begin
            if (count_q != limit_q) begin
                count_d = count_q + WIDTH'(1);
            end else if (bus.auto_reload) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                state_d = HALT;
            end
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COUNT;
            count_q  <= '0;
            limit_q  <= '1;
            wrap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            wrap_q   <= wrap_d;
            halted_q <= halted_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.tc     = (count_q == limit_q);
    assign bus.wrap   = wrap_q;
    assign bus.halted = halted_q;

endmodule
